// File: rtl/warehouse_pkg.sv
// warehouse_pkg: shared storage codes, FSM encoding and error-bit indices for the command decoder.
package warehouse_pkg;
  localparam logic [7:0] STO_A1 = 8'd103, STO_A2 = 8'd104, STO_A3 = 8'd105;
  localparam logic [7:0] STO_B1 = 8'd107, STO_B2 = 8'd108, STO_B3 = 8'd109;
  localparam logic [7:0] STO_C1 = 8'd111, STO_C2 = 8'd112, STO_C3 = 8'd113;
  localparam logic [7:0] POS_HOME_DEF = 8'd16;
  localparam logic [7:0] POS_MAX = 8'd16;
  typedef enum logic [1:0] {IDLE = 2'd0, MISSION = 2'd1, HOME = 2'd2} state_t;
  localparam int ERR_POS = 0;
  localparam int ERR_STO = 1;
  localparam int ERR_TMO = 2;
  function automatic logic sto_legal(input logic [7:0] c);
    return c inside {STO_A1, STO_A2, STO_A3, STO_B1, STO_B2, STO_B3, STO_C1, STO_C2, STO_C3};
  endfunction
endpackage

// File: rtl/cmd_watchdog.sv
// cmd_watchdog: saturating cycle counter; expired holds once LIMIT cycles have been counted since clear.
module cmd_watchdog #(
  parameter int unsigned LIMIT = 150_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = LIMIT > 1 ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] TOP = CW'(LIMIT - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en && cnt != TOP) cnt <= cnt + CW'(1);
  end
  assign expired = cnt == TOP;
endmodule

// File: rtl/warehouse_cmd_decoder.sv
// warehouse_cmd_decoder: validates position/storage UART bytes, runs the mission FSM and link watchdog.
// Define CMD_ECHO_EN to drive the LED bank with the last accepted byte instead of state/error status.
module warehouse_cmd_decoder
  import warehouse_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TIMEOUT_MS = 3000,
  parameter logic [7:0]  POS_HOME   = POS_HOME_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pos_rx_valid,
  input  logic [7:0] pos_rx_data,
  input  logic       sto_rx_valid,
  input  logic [7:0] sto_rx_data,
  input  logic       err_clr,
  output logic [7:0] position,
  output logic [7:0] storage,
  output logic       pos_update,
  output logic       sto_update,
  output logic       mission_done,
  output logic [2:0] err_flags,
  output logic [7:0] diode
);
  localparam longint LIMIT_L = longint'(TIMEOUT_MS) * longint'(CLK_HZ) / 64'sd1000;
  state_t state, state_n;
  logic pos_ok, sto_ok, go_home, timeout, expired;
  logic [2:0] err_evt;
  cmd_watchdog #(.LIMIT(int'(LIMIT_L))) u_wd (
    .clk(clk),
    .rst(rst),
    .clr(pos_ok || state != MISSION),
    .en(state == MISSION),
    .expired(expired)
  );
  // Position is judged first against the pre-cycle state; storage only lands in IDLE.
  always_comb begin
    pos_ok = pos_rx_valid && pos_rx_data != 8'd0 && pos_rx_data <= POS_MAX;
    sto_ok = sto_rx_valid && sto_legal(sto_rx_data) && state == IDLE;
    go_home = state == MISSION && pos_ok && pos_rx_data == POS_HOME;
    timeout = state == MISSION && expired && !pos_ok;
    err_evt = '0;
    err_evt[ERR_POS] = pos_rx_valid && !pos_ok;
    err_evt[ERR_STO] = sto_rx_valid && !sto_ok;
    err_evt[ERR_TMO] = timeout;
    state_n = state == IDLE ? (sto_ok ? MISSION : IDLE) :
              state == HOME ? IDLE :
              timeout ? IDLE : go_home ? HOME : MISSION;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      position <= '0;
      storage <= '0;
      pos_update <= 1'b0;
      sto_update <= 1'b0;
      mission_done <= 1'b0;
      err_flags <= '0;
    end else begin
      state <= state_n;
      position <= timeout ? '0 : pos_ok ? pos_rx_data : position;
      storage <= sto_ok ? sto_rx_data : (state == HOME || timeout) ? '0 : storage;
      pos_update <= pos_ok;
      sto_update <= sto_ok || state == HOME || timeout;
      mission_done <= state == HOME;
      err_flags <= (err_clr ? '0 : err_flags) | err_evt;
    end
  end
`ifdef CMD_ECHO_EN
  logic [7:0] echo;
  always_ff @(posedge clk) begin
    if (rst) echo <= '0;
    else echo <= sto_ok ? sto_rx_data : pos_ok ? pos_rx_data : echo;
  end
  assign diode = echo;
`else
  assign diode = {state, 3'b000, err_flags};
`endif
endmodule

// File: tb/tb_warehouse_cmd_decoder.sv
// tb_warehouse_cmd_decoder: directed scenarios plus random strobes checked against a behavioural model.
module tb_warehouse_cmd_decoder;
  localparam int CLK_HZ = 1000;
  localparam int TIMEOUT_MS = 20;
  localparam int LIMIT = CLK_HZ * TIMEOUT_MS / 1000;
  logic clk = 1'b0, rst = 1'b1, pos_rx_valid = 1'b0, sto_rx_valid = 1'b0, err_clr = 1'b0;
  logic [7:0] pos_rx_data = '0, sto_rx_data = '0;
  logic [7:0] position, storage, diode;
  logic pos_update, sto_update, mission_done;
  logic [2:0] err_flags;
  always #5 clk = ~clk;
  warehouse_cmd_decoder #(.CLK_HZ(CLK_HZ), .TIMEOUT_MS(TIMEOUT_MS), .POS_HOME(8'd16)) dut (
    .clk(clk), .rst(rst),
    .pos_rx_valid(pos_rx_valid), .pos_rx_data(pos_rx_data),
    .sto_rx_valid(sto_rx_valid), .sto_rx_data(sto_rx_data),
    .err_clr(err_clr),
    .position(position), .storage(storage),
    .pos_update(pos_update), .sto_update(sto_update),
    .mission_done(mission_done), .err_flags(err_flags), .diode(diode)
  );
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  // Reference model: mission phase 0 idle, 1 mission, 2 home; watchdog as edge-count since last activity.
  logic [7:0] m_pos = 0, m_sto = 0, m_echo = 0;
  logic m_pu = 0, m_su = 0, m_md = 0;
  logic [2:0] m_err = 0;
  logic [1:0] m_st = 0;
  int cyc = 0, last_act = 0;
  function automatic bit legal(input bit [7:0] c);
    return c inside {[103:105], [107:109], [111:113]};
  endfunction
  task automatic model(input bit pv, input bit [7:0] pd, input bit sv, input bit [7:0] sd,
                       input bit ec, input bit rs);
    bit pos_ok, sto_ok, tmo, home;
    logic [1:0] nst;
    cyc++;
    if (rs) begin
      {m_pos, m_sto, m_echo, m_pu, m_su, m_md, m_err, m_st} = '0;
      last_act = cyc;
      return;
    end
    pos_ok = pv && pd >= 1 && pd <= 16;
    sto_ok = sv && legal(sd) && m_st == 0;
    tmo = m_st == 1 && !pos_ok && (cyc - last_act >= LIMIT);
    home = m_st == 1 && pos_ok && pd == 16;
    m_pu = pos_ok;
    m_su = sto_ok || m_st == 2 || tmo;
    m_md = m_st == 2;
    m_err = (ec ? 3'b000 : m_err) | {tmo, sv && !sto_ok, pv && !pos_ok};
    if (tmo) m_pos = 0;
    else if (pos_ok) m_pos = pd;
    if (sto_ok) m_sto = sd;
    else if (m_st == 2 || tmo) m_sto = 0;
    if (sto_ok) m_echo = sd;
    else if (pos_ok) m_echo = pd;
    if (m_st == 0) nst = sto_ok ? 2'd1 : 2'd0;
    else if (m_st == 2 || tmo) nst = 2'd0;
    else nst = home ? 2'd2 : 2'd1;
    if (pos_ok || (nst == 1 && m_st != 1)) last_act = cyc;
    m_st = nst;
  endtask
  task automatic step(input bit pv, input bit [7:0] pd, input bit sv, input bit [7:0] sd,
                      input bit ec, input bit rs);
    pos_rx_valid = pv; pos_rx_data = pd;
    sto_rx_valid = sv; sto_rx_data = sd;
    err_clr = ec; rst = rs;
    model(pv, pd, sv, sd, ec, rs);
    @(negedge clk);
    chk("position", position, m_pos);
    chk("storage", storage, m_sto);
    chk("pos_update", pos_update, m_pu);
    chk("sto_update", sto_update, m_su);
    chk("mission_done", mission_done, m_md);
    chk("err_flags", err_flags, m_err);
`ifdef CMD_ECHO_EN
    chk("diode", diode, m_echo);
`else
    chk("diode", diode, {m_st, 3'b000, m_err});
`endif
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    int quiet = 0;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_outputs", {position, storage, err_flags}, 0);
    step(0, 0, 1, 104, 0, 0);
    chk("t1_storage", storage, 104);
    chk("t1_sto_update", sto_update, 1);
    step(1, 3, 0, 0, 0, 0);
    step(1, 4, 0, 0, 0, 0);
    chk("t1_position", position, 4);
    step(1, 16, 0, 0, 0, 0);
    chk("t2_position", position, 16);
    step(0, 0, 0, 0, 0, 0);
    chk("t2_done", {storage, mission_done, sto_update}, {8'd0, 1'b1, 1'b1});
    step(0, 0, 1, 106, 0, 0);
    chk("t3_bad_sto", {err_flags[1], storage}, {1'b1, 8'd0});
    step(0, 0, 1, 103, 1, 0);
    step(0, 0, 1, 108, 0, 0);
    chk("t3_busy", {err_flags[1], storage}, {1'b1, 8'd103});
    step(1, 16, 0, 0, 0, 0);
    idle(1);
    step(1, 0, 0, 0, 1, 0);
    step(1, 17, 0, 0, 0, 0);
    chk("t4_bad_pos", {err_flags[0], position}, {1'b1, 8'd16});
    step(0, 0, 0, 0, 1, 0);
    chk("t4_clr", err_flags, 0);
    step(0, 0, 1, 105, 0, 0);
    idle(LIMIT - 1);
    chk("t5_before", storage, 105);
    idle(1);
    chk("t5_timeout", {err_flags[2], storage, position, mission_done}, {1'b1, 16'd0, 1'b0});
    step(1, 5, 1, 112, 1, 0);
    chk("t6_both", {position, storage, pos_update, sto_update}, {8'd5, 8'd112, 2'b11});
    step(1, 16, 1, 103, 0, 0);
    chk("t6_busy", {position, err_flags[1]}, {8'd16, 1'b1});
    step(0, 0, 0, 0, 0, 0);
    chk("t6_home", {storage, mission_done}, {8'd0, 1'b1});
    step(0, 0, 1, 107, 0, 0);
    step(1, 2, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("t6_rst", {position, storage, pos_update, sto_update, mission_done, err_flags},
        '0);
    for (int i = 0; i < 3000; i++) begin
      if (quiet == 0 && $urandom_range(0, 149) == 0) quiet = LIMIT + 5;
      if (quiet > 0) begin
        quiet--;
        step(0, 0, 0, 0, $urandom_range(0, 19) == 0, 0);
      end else
        step($urandom_range(0, 9) < 3, 8'($urandom_range(0, 20)),
             $urandom_range(0, 9) == 0, 8'($urandom_range(100, 115)),
             $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
